// File: rtl/player_life_ctrl.sv
// Player life controller: tracks lives, post-hit invulnerability with sprite
// blinking, and the game-over condition. All outputs come straight from flops.
module player_life_ctrl #(
  parameter int INIT_LIVES   = 3,
  parameter int INVUL_FRAMES = 120,
  parameter int BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       collision,
  output logic [2:0] lives,
  output logic       invincible,
  output logic       player_visible,
  output logic       hit_pulse,
  output logic       game_over,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIVE = 2'd1,
    S_INVUL = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  localparam logic [2:0] INIT_LD  = 3'(INIT_LIVES);
  localparam logic [7:0] INVUL_LD = 8'(INVUL_FRAMES);
  localparam logic [7:0] BLINK_LD = 8'(BLINK_FRAMES);

  state_e     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] invul_q, invul_d;
  logic [7:0] blink_q, blink_d;
  logic       hit_q, hit_d;
  logic       vis_q, vis_d;
  logic       inv_q, inv_d;
  logic       over_q, over_d;
  logic       blink_tog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lives_q <= 3'd0;
      invul_q <= 8'd0;
      blink_q <= 8'd0;
      hit_q   <= 1'b0;
      vis_q   <= 1'b0;
      inv_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      invul_q <= invul_d;
      blink_q <= blink_d;
      hit_q   <= hit_d;
      vis_q   <= vis_d;
      inv_q   <= inv_d;
      over_q  <= over_d;
    end
  end

  // Start wins over collision in IDLE/OVER; collision is only judged in ALIVE,
  // so a final-tick collision is seen one edge later.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    invul_d   = invul_q;
    blink_d   = blink_q;
    hit_d     = 1'b0;
    blink_tog = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_ALIVE;
          lives_d = INIT_LD;
          invul_d = 8'd0;
          blink_d = 8'd0;
        end
      end
      S_ALIVE: begin
        if (collision) begin
          hit_d = 1'b1;
          if (lives_q > 3'd1) begin
            state_d = S_INVUL;
            lives_d = lives_q - 3'd1;
            invul_d = INVUL_LD;
            blink_d = BLINK_LD;
          end else begin
            state_d = S_OVER;
            lives_d = 3'd0;
          end
        end
      end
      S_INVUL: begin
        if (frame_tick) begin
          if (invul_q == 8'd1) begin
            state_d = S_ALIVE;
            invul_d = 8'd0;
            blink_d = 8'd0;
          end else begin
            invul_d = invul_q - 8'd1;
            if (blink_q == 8'd1) begin
              blink_d   = BLINK_LD;
              blink_tog = 1'b1;
            end else begin
              blink_d = blink_q - 8'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are derived from the state being entered.
  always_comb begin
    inv_d  = (state_d == S_INVUL);
    over_d = (state_d == S_OVER);
    vis_d  = 1'b0;
    case (state_d)
      S_ALIVE: vis_d = 1'b1;
      S_INVUL: vis_d = (state_q == S_INVUL) ? (vis_q ^ blink_tog) : 1'b0;
      default: vis_d = 1'b0;
    endcase
  end

  assign lives          = lives_q;
  assign invincible     = inv_q;
  assign player_visible = vis_q;
  assign hit_pulse      = hit_q;
  assign game_over      = over_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_player_life_ctrl.sv
// Bench for player_life_ctrl: directed scenarios followed by random play, all
// checked cycle by cycle against a tick-counting game model.
module tb_player_life_ctrl;

  localparam int INIT_LIVES   = 3;
  localparam int INVUL_FRAMES = 120;
  localparam int BLINK_FRAMES = 8;

  logic       clk;
  logic       rst;
  logic       start;
  logic       frame_tick;
  logic       collision;
  logic [2:0] lives;
  logic       invincible;
  logic       player_visible;
  logic       hit_pulse;
  logic       game_over;
  logic [1:0] dbg_state;

  int n_checks;
  int n_fail;

  // Model: phase 0 idle, 1 playing, 2 invulnerable, 3 game over.
  int m_phase;
  int m_lives;
  int m_ticks;
  int m_hit;

  player_life_ctrl #(
    .INIT_LIVES  (INIT_LIVES),
    .INVUL_FRAMES(INVUL_FRAMES),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .frame_tick    (frame_tick),
    .collision     (collision),
    .lives         (lives),
    .invincible    (invincible),
    .player_visible(player_visible),
    .hit_pulse     (hit_pulse),
    .game_over     (game_over),
    .dbg_state     (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_lives = 0;
    m_ticks = 0;
    m_hit   = 0;
  endtask

  task automatic model_step(input logic st, input logic ft, input logic col);
    m_hit = 0;
    case (m_phase)
      0, 3: if (st) begin
        m_phase = 1;
        m_lives = INIT_LIVES;
        m_ticks = 0;
      end
      1: if (col) begin
        m_hit = 1;
        if (m_lives > 1) begin
          m_lives = m_lives - 1;
          m_phase = 2;
          m_ticks = 0;
        end else begin
          m_lives = 0;
          m_phase = 3;
        end
      end
      default: if (ft) begin
        m_ticks = m_ticks + 1;
        if (m_ticks == INVUL_FRAMES) m_phase = 1;
      end
    endcase
  endtask

  task automatic compare_all();
    int exp_vis;
    if (m_phase == 1)      exp_vis = 1;
    else if (m_phase == 2) exp_vis = (m_ticks / BLINK_FRAMES) % 2;
    else                   exp_vis = 0;
    check("lives",      8'(lives),          8'(m_lives));
    check("invincible", 8'(invincible),     8'(m_phase == 2));
    check("visible",    8'(player_visible), 8'(exp_vis));
    check("hit_pulse",  8'(hit_pulse),      8'(m_hit));
    check("game_over",  8'(game_over),      8'(m_phase == 3));
  endtask

  task automatic cycle(input logic st, input logic ft, input logic col);
    @(negedge clk);
    start      = st;
    frame_tick = ft;
    collision  = col;
    @(posedge clk);
    model_step(st, ft, col);
    #1;
    compare_all();
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    start      = 1'b0;
    frame_tick = 1'b0;
    collision  = 1'b0;
    rst        = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int hits;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    frame_tick = 1'b0;
    collision  = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Start from reset.
    cycle(1'b1, 1'b0, 1'b0);
    check("start_lives", 8'(lives), 8'd3);
    check("start_vis",   8'(player_visible), 8'd1);

    // Held collision without frame ticks: one hit only.
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (hit_pulse) hits++;
    end
    check("held_col_hits", 8'(hits), 8'd1);
    check("held_col_lives", 8'(lives), 8'd2);
    check("held_col_inv", 8'(invincible), 8'd1);

    // Full invulnerability window, ticks spaced 10 cycles.
    for (int t = 0; t < INVUL_FRAMES; t++) begin
      cycle(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0, 1'b0);
    end
    check("invul_end_inv", 8'(invincible), 8'd0);
    check("invul_end_vis", 8'(player_visible), 8'd1);

    // Second hit, then collision on the final tick.
    cycle(1'b0, 1'b0, 1'b1);
    check("hit2_lives", 8'(lives), 8'd1);
    for (int t = 0; t < INVUL_FRAMES - 1; t++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    check("final_tick_hit", 8'(hit_pulse), 8'd0);
    check("final_tick_inv", 8'(invincible), 8'd0);
    cycle(1'b0, 1'b0, 1'b1);
    check("hit3_pulse", 8'(hit_pulse), 8'd1);
    check("hit3_lives", 8'(lives), 8'd0);
    check("hit3_over", 8'(game_over), 8'd1);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1);
      if (hit_pulse) hits++;
    end
    check("over_hits", 8'(hits), 8'd0);

    // Reset mid-invulnerability with one life left.
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    for (int t = 0; t < INVUL_FRAMES; t++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("pre_rst_lives", 8'(lives), 8'd1);
    for (int t = 0; t < 5; t++) cycle(1'b0, 1'b1, 1'b0);
    reset_pulse();
    cycle(1'b1, 1'b0, 1'b1);
    check("restart_lives", 8'(lives), 8'd3);
    check("restart_hit", 8'(hit_pulse), 8'd0);
    cycle(1'b0, 1'b0, 1'b0);
    check("restart_hit_next", 8'(hit_pulse), 8'd0);

    // Random play with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) reset_pulse();
      else cycle(1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/player_life_ctrl.md
PLAYER_LIFE_CTRL -- requirements
Module: player_life_ctrl

Interface
REQ-001 Parameter INIT_LIVES, default 3: lives loaded on start; legal range 1..7.
REQ-002 Parameter INVUL_FRAMES, default 120: invulnerability length in frames after a non-fatal hit; legal range 1..255.
REQ-003 Parameter BLINK_FRAMES, default 8: frames per visibility half-period while invulnerable; legal range 1..255.
REQ-004 clk  in  1  system clock; the single clock of the block.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 start  in  1  single-cycle request to begin or restart a game.
REQ-007 frame_tick  in  1  single-cycle pulse, once per video frame.
REQ-008 collision  in  1  registered level from the collision judge; high while the player overlaps the boss or the moon bullet.
REQ-009 lives  out  3  remaining lives, unsigned.
REQ-010 invincible  out  1  high while hits are ignored.
REQ-011 player_visible  out  1  sprite enable for the player renderer.
REQ-012 hit_pulse  out  1  one-cycle pulse per accepted hit.
REQ-013 game_over  out  1  high while in state OVER.

Function
REQ-014 FSM states: IDLE, ALIVE, INVUL, OVER; all outputs registered.
REQ-015 IDLE: start=1 -> ALIVE, lives<=INIT_LIVES, counters cleared; collision ignored.
REQ-016 ALIVE: collision=1 sampled at an edge is an accepted hit; hit_pulse=1 for the following cycle only.
REQ-017 Accepted hit with lives>1 -> INVUL, lives<=lives-1, invul counter<=INVUL_FRAMES, blink counter<=BLINK_FRAMES, player_visible<=0.
REQ-018 Accepted hit with lives==1 -> OVER, lives<=0; lives never decrements below 0.
REQ-019 INVUL: collision ignored; each frame_tick decrements the invul counter; when the counter is 1 at a frame_tick -> ALIVE.
REQ-020 INVUL: each frame_tick decrements the blink counter; at 1 it reloads BLINK_FRAMES and player_visible toggles.
REQ-021 Collision and the final frame_tick in the same cycle: transition to ALIVE, no hit taken; a still-high collision hits on the next edge.
REQ-022 No frame_tick means no progress in INVUL; collision level held high causes exactly one hit per ALIVE entry.
REQ-023 OVER: game_over=1, lives=0, player_visible=0; start=1 -> ALIVE with lives<=INIT_LIVES.
REQ-024 start is ignored in ALIVE and INVUL; start has priority over collision in IDLE and OVER.
REQ-025 invincible=1 exactly in INVUL; player_visible=1 in ALIVE, 0 in IDLE and OVER.
REQ-026 Lives update, state change and hit_pulse take effect on the same clock edge (latency 1 cycle from sampled collision).

Reset
REQ-027 rst=1 forces state IDLE, lives=0, invincible=0, player_visible=0, hit_pulse=0, game_over=0, all counters 0, immediately and regardless of clk.
REQ-028 rst asserted mid-INVUL or mid-hit aborts the operation; no hit_pulse is emitted after reset release without a fresh accepted hit.

Verification
REQ-029 rst, then start pulse -> next cycle lives=3, player_visible=1, invincible=0, game_over=0.
REQ-030 In ALIVE with lives=3, collision held high for 200 cycles with no frame_tick -> exactly one hit_pulse, lives=2, invincible=1.
REQ-031 INVUL with 120 frame_ticks (spaced 10 cycles) -> player_visible toggles every 8 ticks, invincible falls on the 120th tick edge, then ALIVE with player_visible=1.
REQ-032 Three accepted hits from lives=3 -> lives 2,1,0; third hit enters OVER, game_over=1, invincible=0; further collisions produce no hit_pulse.
REQ-033 Collision high on the 120th INVUL frame_tick cycle -> ALIVE, no hit that cycle; hit_pulse on the next cycle, lives decremented by 1.
REQ-034 rst pulsed for 1 cycle mid-INVUL with lives=1 -> IDLE, all outputs 0; start plus simultaneous collision -> ALIVE, lives=3, no hit_pulse.
